// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM state encoding and instruction size.
// No logic, so no latency or backpressure of its own.
package fetch_pkg;

    typedef enum logic {FETCH_REQ, FETCH_VALID} fetch_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bundle: instruction-memory req/ack, decode valid/ready and decode feedback.
// Master is the fetch unit; slave is memory plus decode.
interface fetch_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_o;
    logic [DATA_WIDTH-1:0] imem_addr_o;
    logic                  imem_ack_i;
    logic [DATA_WIDTH-1:0] imem_rdata_i;
    logic [DATA_WIDTH-1:0] instr_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] pc_plus4_o;
    logic                  instr_valid_o;
    logic                  instr_ready_i;
    logic                  PCSrc_i;
    logic [DATA_WIDTH-1:0] ImmOp_i;
    logic [DATA_WIDTH-1:0] instr_count_o;
    logic                  misalign_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_o, pc_o, pc_plus4_o,
               instr_valid_o, instr_count_o, misalign_o,
        input  imem_ack_i, imem_rdata_i, instr_ready_i, PCSrc_i, ImmOp_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_o, pc_o, pc_plus4_o,
               instr_valid_o, instr_count_o, misalign_o,
        output imem_ack_i, imem_rdata_i, instr_ready_i, PCSrc_i, ImmOp_i
    );
endinterface

// File: rtl/fetch_pc_next.sv
// Next-PC select (PC+4 or PC+imm) with redirect alignment force and misalign flag.
// Purely combinational; no backpressure.
module pc_next
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic                  pc_src_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic [DATA_WIDTH-1:0] next_pc_o,
    output logic                  misalign_o
);

    logic [DATA_WIDTH-1:0] target;

    assign target = pc_i + imm_i;

    // Only the redirect path can land off a word boundary.
    assign misalign_o = pc_src_i && (target[1:0] != 2'b00);
    assign next_pc_o  = pc_src_i ? {target[DATA_WIDTH-1:2], 2'b00}
                                 : pc_i + DATA_WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ack, hands instr+pc to decode.
// Valid the cycle after ack; holds instr/pc while instr_ready_i is low (max 1 instr / 2 cycles).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic     clk_i,
    input  logic     rst_i,
    fetch_if.master  bus
);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] count_q, count_d;
    logic                  misalign_q, misalign_d;

    logic [DATA_WIDTH-1:0] next_pc;
    logic                  next_misalign;

    pc_next #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_pc_next (
        .pc_i       (pc_q),
        .pc_src_i   (bus.PCSrc_i),
        .imm_i      (bus.ImmOp_i),
        .next_pc_o  (next_pc),
        .misalign_o (next_misalign)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= FETCH_REQ;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        case (state_q)
            FETCH_REQ: begin
                if (bus.imem_ack_i) begin
                    instr_d = bus.imem_rdata_i;
                    state_d = FETCH_VALID;
                end
            end
            FETCH_VALID: begin
                // Decode feedback is only meaningful on the consuming cycle.
                if (bus.instr_ready_i) begin
                    pc_d       = next_pc;
                    count_d    = count_q + DATA_WIDTH'(1);
                    misalign_d = misalign_q | next_misalign;
                    state_d    = FETCH_REQ;
                end
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    assign bus.imem_req_o    = (state_q == FETCH_REQ);
    assign bus.imem_addr_o   = pc_q;
    assign bus.instr_valid_o = (state_q == FETCH_VALID);
    assign bus.instr_o       = instr_q;
    assign bus.pc_o          = pc_q;
    assign bus.pc_plus4_o    = pc_q + DATA_WIDTH'(INSTR_BYTES);
    assign bus.instr_count_o = count_q;
    assign bus.misalign_o    = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task drives a scenario and checks hand-computed values.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [31:0] held;

    always #5 clk = ~clk;

    fetch_if #(.DATA_WIDTH(32)) bus ();

    fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.imem_ack_i = 1'b0; bus.imem_rdata_i = 32'h0; bus.instr_ready_i = 1'b0;
        bus.PCSrc_i = 1'b0; bus.ImmOp_i = 32'h0;
        rst = 1'b1;
        tick(); tick();
        n_chk++; if (bus.imem_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_req: got %b want 1", bus.imem_req_o); end
        n_chk++; if (bus.imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr_o); end
        n_chk++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.instr_valid_o); end
        n_chk++; if (bus.instr_o !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", bus.instr_o); end
        n_chk++; if (bus.pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", bus.pc_o); end
        n_chk++; if (bus.pc_plus4_o !== 32'h4) begin n_fail++; $display("FAIL rst_pc4: got %h want 4", bus.pc_plus4_o); end
        n_chk++; if (bus.instr_count_o !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", bus.instr_count_o); end
        n_chk++; if (bus.misalign_o !== 1'b0) begin n_fail++; $display("FAIL rst_mis: got %b want 0", bus.misalign_o); end
        rst = 1'b0;
        tick();
    endtask

    // Zero-wait memory, always ready: fetches at 0x0, 0x4, 0x8, two cycles apart.
    task automatic test_zero_wait();
        bus.imem_ack_i = 1'b1; bus.instr_ready_i = 1'b1; bus.PCSrc_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.imem_rdata_i = 32'hA000_0000 + 32'(k);
            tick();
            n_chk++; if (bus.instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL zw_valid%0d: got %b want 1", k, bus.instr_valid_o); end
            n_chk++; if (bus.pc_o !== 32'(4 * k)) begin n_fail++; $display("FAIL zw_pc%0d: got %h want %h", k, bus.pc_o, 32'(4 * k)); end
            n_chk++; if (bus.instr_o !== 32'hA000_0000 + 32'(k)) begin n_fail++; $display("FAIL zw_instr%0d: got %h want %h", k, bus.instr_o, 32'hA000_0000 + 32'(k)); end
            n_chk++; if (bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL zw_noreq%0d: got %b want 0", k, bus.imem_req_o); end
            tick();
            exp_cnt = exp_cnt + 1;
            n_chk++; if (bus.imem_addr_o !== 32'(4 * (k + 1))) begin n_fail++; $display("FAIL zw_addr%0d: got %h want %h", k, bus.imem_addr_o, 32'(4 * (k + 1))); end
            n_chk++; if (bus.instr_count_o !== exp_cnt) begin n_fail++; $display("FAIL zw_cnt%0d: got %h want %h", k, bus.instr_count_o, exp_cnt); end
        end
        bus.imem_ack_i = 1'b0; bus.instr_ready_i = 1'b0;
    endtask

    // Three wait cycles at 0xC; an ack while VALID must not overwrite the instruction.
    task automatic test_wait_states();
        bus.imem_rdata_i = 32'h1234_5678;
        for (int w = 0; w < 3; w++) begin
            tick();
            n_chk++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'hC) begin n_fail++; $display("FAIL ws_hold%0d: got req=%b addr=%h want req=1 addr=c", w, bus.imem_req_o, bus.imem_addr_o); end
            n_chk++; if (bus.instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL ws_novalid%0d: got %b want 0", w, bus.instr_valid_o); end
        end
        bus.imem_ack_i = 1'b1;
        tick();
        n_chk++; if (bus.instr_valid_o !== 1'b1 || bus.instr_o !== 32'h1234_5678) begin n_fail++; $display("FAIL ws_valid: got v=%b instr=%h want v=1 instr=12345678", bus.instr_valid_o, bus.instr_o); end
        bus.imem_rdata_i = 32'hBAD0_BAD0;
        tick(); tick();
        n_chk++; if (bus.instr_o !== 32'h1234_5678) begin n_fail++; $display("FAIL ws_ackign: got %h want 12345678", bus.instr_o); end
        n_chk++; if (bus.instr_valid_o !== 1'b1 || bus.imem_req_o !== 1'b0) begin n_fail++; $display("FAIL ws_state: got v=%b req=%b want v=1 req=0", bus.instr_valid_o, bus.imem_req_o); end
        bus.imem_ack_i = 1'b0; bus.instr_ready_i = 1'b1;
        tick();
        exp_cnt = exp_cnt + 1;
        n_chk++; if (bus.imem_addr_o !== 32'h10 || bus.instr_count_o !== exp_cnt) begin n_fail++; $display("FAIL ws_next: got addr=%h cnt=%h want addr=10 cnt=%h", bus.imem_addr_o, bus.instr_count_o, exp_cnt); end
        bus.instr_ready_i = 1'b0;
    endtask

    // Stall at 0x10 for 5 cycles with junk feedback, then branch back by 8.
    task automatic test_stall();
        bus.imem_rdata_i = 32'hCAFE_0010; bus.imem_ack_i = 1'b1;
        tick();
        bus.imem_ack_i = 1'b0; bus.PCSrc_i = 1'b1; bus.ImmOp_i = 32'h100;
        for (int s = 0; s < 5; s++) begin
            tick();
            n_chk++; if (bus.pc_o !== 32'h10 || bus.instr_o !== 32'hCAFE_0010) begin n_fail++; $display("FAIL st_hold%0d: got pc=%h instr=%h want pc=10 instr=cafe0010", s, bus.pc_o, bus.instr_o); end
            n_chk++; if (bus.instr_valid_o !== 1'b1 || bus.imem_req_o !== 1'b0 || bus.instr_count_o !== exp_cnt) begin n_fail++; $display("FAIL st_state%0d: got v=%b req=%b cnt=%h want v=1 req=0 cnt=%h", s, bus.instr_valid_o, bus.imem_req_o, bus.instr_count_o, exp_cnt); end
        end
        bus.instr_ready_i = 1'b1; bus.ImmOp_i = 32'hFFFF_FFF8;
        tick();
        exp_cnt = exp_cnt + 1;
        n_chk++; if (bus.imem_addr_o !== 32'h08 || bus.imem_req_o !== 1'b1) begin n_fail++; $display("FAIL st_branch: got addr=%h req=%b want addr=8 req=1", bus.imem_addr_o, bus.imem_req_o); end
        n_chk++; if (bus.instr_count_o !== exp_cnt || bus.misalign_o !== 1'b0) begin n_fail++; $display("FAIL st_cnt: got cnt=%h mis=%b want cnt=%h mis=0", bus.instr_count_o, bus.misalign_o, exp_cnt); end
        bus.instr_ready_i = 1'b0; bus.PCSrc_i = 1'b0;
    endtask

    // One fetch at the current PC then consume it with the given feedback.
    task automatic fetch_and_take(input logic src, input logic [31:0] imm);
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h0000_0013;
        tick();
        bus.imem_ack_i = 1'b0; bus.instr_ready_i = 1'b1; bus.PCSrc_i = src; bus.ImmOp_i = imm;
        tick();
        exp_cnt = exp_cnt + 1;
        bus.instr_ready_i = 1'b0; bus.PCSrc_i = 1'b0;
    endtask

    // Jump from 0x8 to 0xFFFF_FFFC, then PC+4 wraps to 0 without misalign.
    task automatic test_wrap();
        fetch_and_take(1'b1, 32'hFFFF_FFF4);
        n_chk++; if (bus.imem_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_top: got %h want fffffffc", bus.imem_addr_o); end
        bus.imem_ack_i = 1'b1;
        tick();
        n_chk++; if (bus.pc_plus4_o !== 32'h0) begin n_fail++; $display("FAIL wr_pc4: got %h want 0", bus.pc_plus4_o); end
        bus.imem_ack_i = 1'b0; bus.instr_ready_i = 1'b1;
        tick();
        exp_cnt = exp_cnt + 1;
        bus.instr_ready_i = 1'b0;
        n_chk++; if (bus.imem_addr_o !== 32'h0 || bus.misalign_o !== 1'b0) begin n_fail++; $display("FAIL wr_zero: got addr=%h mis=%b want addr=0 mis=0", bus.imem_addr_o, bus.misalign_o); end
        n_chk++; if (bus.instr_count_o !== exp_cnt) begin n_fail++; $display("FAIL wr_cnt: got %h want %h", bus.instr_count_o, exp_cnt); end
    endtask

    // JAL-style redirect from 0x100 by 0x802 lands on 0x900 and sets sticky misalign.
    task automatic test_redirect();
        fetch_and_take(1'b1, 32'h0000_0100);
        bus.imem_ack_i = 1'b1;
        tick();
        n_chk++; if (bus.pc_o !== 32'h100 || bus.pc_plus4_o !== 32'h104) begin n_fail++; $display("FAIL rd_link: got pc=%h pc4=%h want pc=100 pc4=104", bus.pc_o, bus.pc_plus4_o); end
        bus.imem_ack_i = 1'b0; bus.instr_ready_i = 1'b1; bus.PCSrc_i = 1'b1; bus.ImmOp_i = 32'h0000_0802;
        tick();
        exp_cnt = exp_cnt + 1;
        bus.instr_ready_i = 1'b0; bus.PCSrc_i = 1'b0;
        n_chk++; if (bus.imem_addr_o !== 32'h900 || bus.misalign_o !== 1'b1) begin n_fail++; $display("FAIL rd_target: got addr=%h mis=%b want addr=900 mis=1", bus.imem_addr_o, bus.misalign_o); end
        fetch_and_take(1'b0, 32'h0);
        n_chk++; if (bus.imem_addr_o !== 32'h904 || bus.misalign_o !== 1'b1) begin n_fail++; $display("FAIL rd_sticky: got addr=%h mis=%b want addr=904 mis=1", bus.imem_addr_o, bus.misalign_o); end
        n_chk++; if (bus.instr_count_o !== exp_cnt) begin n_fail++; $display("FAIL rd_cnt: got %h want %h", bus.instr_count_o, exp_cnt); end
    endtask

    // Reset asserted mid-wait at 0x40 takes effect without a clock edge.
    task automatic test_reset_mid_wait();
        fetch_and_take(1'b1, 32'hFFFF_F73C);
        n_chk++; if (bus.imem_addr_o !== 32'h40) begin n_fail++; $display("FAIL mr_addr: got %h want 40", bus.imem_addr_o); end
        tick();
        held = bus.imem_addr_o;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (bus.imem_addr_o !== 32'h0 || bus.imem_req_o !== 1'b1) begin n_fail++; $display("FAIL mr_reqaddr: got addr=%h req=%b want addr=0 req=1 (was %h)", bus.imem_addr_o, bus.imem_req_o, held); end
        n_chk++; if (bus.instr_valid_o !== 1'b0 || bus.instr_count_o !== 32'h0 || bus.misalign_o !== 1'b0 || bus.instr_o !== 32'h0) begin n_fail++; $display("FAIL mr_clear: got v=%b cnt=%h mis=%b instr=%h want all 0", bus.instr_valid_o, bus.instr_count_o, bus.misalign_o, bus.instr_o); end
        tick();
        rst = 1'b0;
        bus.imem_ack_i = 1'b1; bus.imem_rdata_i = 32'h5555_AAAA;
        tick();
        bus.imem_ack_i = 1'b0;
        n_chk++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h0 || bus.instr_o !== 32'h5555_AAAA) begin n_fail++; $display("FAIL mr_refetch: got v=%b pc=%h instr=%h want v=1 pc=0 instr=5555aaaa", bus.instr_valid_o, bus.pc_o, bus.instr_o); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_wrap();
        test_redirect();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
